// File: rtl/led_status_if.sv
// Host-side signal bundle for the LED status engine.
// The master side drives link health, overrides and events; the slave side returns LED drive and mode.
`timescale 1ns / 1ps

interface led_status_if #(
    parameter int unsigned N_EVT = 8,
    parameter int unsigned N_BAR = 8
);
    logic                   link_ok;
    logic                   sync_mode;
    logic [N_EVT+N_BAR-1:0] sync_data;
    logic [N_EVT-1:0]       evt_i;
    logic [N_BAR-1:0]       bar_i;
    logic                   activity_i;
    logic                   run_reset;
    logic [N_EVT+N_BAR-1:0] led_out;
    logic [1:0]             mode_o;

    modport master (
        output link_ok, sync_mode, sync_data, evt_i, bar_i, activity_i, run_reset,
        input  led_out, mode_o
    );

    modport slave (
        input  link_ok, sync_mode, sync_data, evt_i, bar_i, activity_i, run_reset,
        output led_out, mode_o
    );
endinterface

// File: rtl/led_status_engine.sv
// Status LED engine: link-fault PWM fader, cylon sweep, run-time bar plus stretched event flashes,
// and a host override pattern, selected by a four-state mode FSM.
`timescale 1ns / 1ps

module led_status_engine #(
    parameter int unsigned N_EVT          = 8,
    parameter int unsigned N_BAR          = 8,
    parameter int unsigned STRETCH_CYC    = 2048,
    parameter int unsigned CYLON_DIV_BITS = 20,
    parameter int unsigned FADE_BITS      = 27
) (
    input logic         clock,
    input logic         reset_n,
    led_status_if.slave bus
);
    localparam int unsigned      LedW       = N_EVT + N_BAR;
    localparam int unsigned      PosW       = (N_BAR > 1) ? $clog2(N_BAR) : 1;
    localparam logic [PosW-1:0]  PosMax     = PosW'(N_BAR - 1);
    localparam logic [23:0]      StretchVal = 24'(STRETCH_CYC);

    typedef enum logic [1:0] {
        StFault = 2'd0,
        StCylon = 2'd1,
        StRun   = 2'd2,
        StSync  = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] deb_q, deb_d;

    // Mode FSM: link loss dominates, then sync override, then run control.
    always_comb begin
        state_d = state_q;
        deb_d   = 4'd0;
        if (!bus.link_ok) begin
            state_d = StFault;
        end else begin
            unique case (state_q)
                StFault: begin
                    if (deb_q == 4'd15) state_d = StCylon;
                    else                deb_d   = deb_q + 4'd1;
                end
                StCylon: begin
                    if (bus.sync_mode)                          state_d = StSync;
                    else if (bus.activity_i && !bus.run_reset)  state_d = StRun;
                end
                StRun: begin
                    if (bus.sync_mode)      state_d = StSync;
                    else if (bus.run_reset) state_d = StCylon;
                end
                StSync: begin
                    if (!bus.sync_mode) state_d = StCylon;
                end
                default: state_d = StFault;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFault;
            deb_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
        end
    end

    // Event flash stretchers; a held or repeated strobe reloads the full duration.
    logic [23:0]      flash_cnt_q [N_EVT];
    logic [N_EVT-1:0] flash;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_EVT; k++) flash_cnt_q[k] <= 24'd0;
        end else begin
            for (int k = 0; k < N_EVT; k++) begin
                if (bus.evt_i[k])               flash_cnt_q[k] <= StretchVal;
                else if (flash_cnt_q[k] != '0)  flash_cnt_q[k] <= flash_cnt_q[k] - 24'd1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_EVT; k++) flash[k] = (flash_cnt_q[k] != 24'd0);
    end

    // Cylon sweep: bounces between the end bits without dwelling twice on either end.
    logic [CYLON_DIV_BITS-1:0] presc_q, presc_d;
    logic [PosW-1:0]           pos_q, pos_d;
    logic                      dir_down_q, dir_down_d;
    logic                      cylon_restart;
    logic [N_BAR-1:0]          cylon;

    assign cylon_restart = bus.run_reset || ((state_d == StCylon) && (state_q != StCylon));

    always_comb begin
        presc_d    = presc_q + CYLON_DIV_BITS'(1);
        pos_d      = pos_q;
        dir_down_d = dir_down_q;
        if (cylon_restart) begin
            presc_d    = '0;
            pos_d      = '0;
            dir_down_d = 1'b0;
        end else if ((&presc_q) && (N_BAR > 1)) begin
            if (!dir_down_q) begin
                if (pos_q == PosMax) begin
                    dir_down_d = 1'b1;
                    pos_d      = pos_q - PosW'(1);
                end else begin
                    pos_d = pos_q + PosW'(1);
                end
            end else begin
                if (pos_q == '0) begin
                    dir_down_d = 1'b0;
                    pos_d      = pos_q + PosW'(1);
                end else begin
                    pos_d = pos_q - PosW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q    <= '0;
            pos_q      <= '0;
            dir_down_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            pos_q      <= pos_d;
            dir_down_q <= dir_down_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_BAR; i++) cylon[i] = (pos_q == PosW'(i));
    end

    // Fader: triangle brightness from the counter top bits, first-order delta-sigma to one bit.
    logic [FADE_BITS-1:0] fade_q;
    logic [4:0]           acc_q, acc_d;
    logic [3:0]           bright;

    assign bright = fade_q[FADE_BITS-1] ? fade_q[FADE_BITS-2 -: 4] : ~fade_q[FADE_BITS-2 -: 4];
    assign acc_d  = {1'b0, acc_q[3:0]} + {1'b0, bright} + 5'd8;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fade_q <= '0;
            acc_q  <= 5'd0;
        end else begin
            fade_q <= fade_q + FADE_BITS'(1);
            acc_q  <= acc_d;
        end
    end

    // Output mux registered off the current state.
    logic [LedW-1:0] led_q, led_d;

    always_comb begin
        led_d = '0;
        unique case (state_q)
            StFault: led_d = {LedW{acc_q[4]}};
            StCylon: led_d = {flash, cylon};
            StRun:   led_d = {flash, bus.bar_i};
            StSync:  led_d = bus.sync_data;
            default: led_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) led_q <= '0;
        else          led_q <= led_d;
    end

    assign bus.led_out = led_q;
    assign bus.mode_o  = state_q;

endmodule

// File: tb/tb_led_status_engine.sv
// Directed bench for led_status_engine: vector table for steady-state modes plus hand sequences
// for debounce, fault/restore and asynchronous reset.
`timescale 1ns / 1ps

module tb_led_status_engine;
    logic clock;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    led_status_if #(.N_EVT(4), .N_BAR(4)) bus ();

    led_status_engine #(
        .N_EVT         (4),
        .N_BAR         (4),
        .STRETCH_CYC   (5),
        .CYLON_DIV_BITS(2),
        .FADE_BITS     (8)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference fader: the LED value the FAULT state registers at each edge.
    logic [7:0] m_fade;
    logic [4:0] m_acc;
    logic [7:0] exp_fault_led;

    function automatic logic [3:0] fade_b(input logic [7:0] f);
        logic [3:0] b;
        b = f[6:3];
        return f[7] ? b : ~b;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_fade        <= 8'd0;
            m_acc         <= 5'd0;
            exp_fault_led <= 8'd0;
        end else begin
            exp_fault_led <= {8{m_acc[4]}};
            m_fade        <= m_fade + 8'd1;
            m_acc         <= {1'b0, m_acc[3:0]} + {1'b0, fade_b(m_fade)} + 5'd8;
        end
    end

    typedef struct {
        logic       link;
        logic       sm;
        logic       act;
        logic       rr;
        logic [3:0] evt;
        logic [3:0] bar;
        logic [7:0] sd;
        logic [1:0] mode;
        logic [7:0] led;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] cyl_seq [0:6];

    function automatic void add(input logic sm, input logic act, input logic rr,
                                input logic [3:0] evt, input logic [3:0] bar,
                                input logic [7:0] sd, input logic [1:0] mode,
                                input logic [7:0] led);
        vec_t v;
        v.link = 1'b1; v.sm = sm; v.act = act; v.rr = rr;
        v.evt = evt; v.bar = bar; v.sd = sd; v.mode = mode; v.led = led;
        tbl.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.link_ok    = 1'b1;
        bus.sync_mode  = 1'b0;
        bus.sync_data  = 8'h00;
        bus.evt_i      = 4'h0;
        bus.bar_i      = 4'h0;
        bus.activity_i = 1'b0;
        bus.run_reset  = 1'b0;
    endtask

    initial begin
        // Cylon + flash phase, rows 1..28 after CYLON entry.
        cyl_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        for (int e = 1; e <= 28; e++) begin
            add(1'b0, 1'b0, 1'b0, (e == 1 || e == 4) ? 4'b0100 : 4'b0000, 4'h0, 8'h00, 2'd1,
                {(e >= 2 && e <= 9) ? 4'b0100 : 4'b0000, cyl_seq[(e - 1) / 4]});
        end
        //  sm    act   rr    evt   bar   sd     mode  led
        add(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 8'h00, 2'd1, 8'h02);  // 29 run_reset mid-sweep
        add(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 2'd1, 8'h01);  // 30 back to bit 0
        add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 8'h00, 2'd1, 8'h01);  // 31 run_reset beats activity
        add(1'b0, 1'b1, 1'b0, 4'h0, 4'hA, 8'h00, 2'd2, 8'h01);  // 32 -> RUN
        add(1'b0, 1'b0, 1'b0, 4'h0, 4'h5, 8'h00, 2'd2, 8'h05);  // 33 bar passes through
        add(1'b0, 1'b0, 1'b0, 4'h0, 4'h3, 8'h00, 2'd2, 8'h03);
        add(1'b1, 1'b0, 1'b0, 4'h0, 4'h3, 8'hA5, 2'd3, 8'h03);  // 35 -> SYNC
        add(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 8'h5A, 2'd3, 8'h5A);
        add(1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 8'hC3, 2'd3, 8'hC3);  // 37 run_reset ignored in SYNC
        add(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h99, 2'd1, 8'h99);  // 38 SYNC -> CYLON
        add(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 2'd1, 8'h01);  // 39 sweep restarted on entry
        add(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 2'd2, 8'h01);
        add(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 8'h00, 2'd2, 8'h0F);
        add(1'b0, 1'b0, 1'b1, 4'h0, 4'h6, 8'h00, 2'd1, 8'h06);  // 42 RUN -> CYLON
        add(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 2'd2, 8'h01);
        add(1'b0, 1'b0, 1'b0, 4'h1, 4'h9, 8'h00, 2'd2, 8'h09);  // 44 flash in RUN
        add(1'b0, 1'b0, 1'b0, 4'h0, 4'h9, 8'h00, 2'd2, 8'h19);
        add(1'b0, 1'b0, 1'b0, 4'h0, 4'h9, 8'h00, 2'd2, 8'h19);
        add(1'b1, 1'b0, 1'b1, 4'h0, 4'h9, 8'h3C, 2'd3, 8'h19);  // 47 sync beats run_reset
        add(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 8'h3C, 2'd3, 8'h3C);
        add(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h3C, 2'd1, 8'h3C);
        add(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 2'd2, 8'h01);  // 50 flash expired

        // Reset state.
        set_idle();
        reset_n = 1'b0;
        tick();
        tick();
        check("reset_mode", 32'(bus.mode_o), 32'd0);
        check("reset_led", 32'(bus.led_out), 32'h00);

        // Debounce with a glitch on the 10th edge: count restarts.
        reset_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            check($sformatf("deb_pre%0d_mode", e), 32'(bus.mode_o), 32'd0);
            check($sformatf("deb_pre%0d_led", e), 32'(bus.led_out), 32'(exp_fault_led));
        end
        bus.link_ok = 1'b0;
        tick();
        check("deb_glitch_mode", 32'(bus.mode_o), 32'd0);
        bus.link_ok = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            check($sformatf("deb_post%0d_mode", e), 32'(bus.mode_o), 32'd0);
        end
        tick();
        check("deb_exit_mode", 32'(bus.mode_o), 32'd1);

        // Vector table, one row per edge.
        foreach (tbl[i]) begin
            bus.link_ok    = tbl[i].link;
            bus.sync_mode  = tbl[i].sm;
            bus.activity_i = tbl[i].act;
            bus.run_reset  = tbl[i].rr;
            bus.evt_i      = tbl[i].evt;
            bus.bar_i      = tbl[i].bar;
            bus.sync_data  = tbl[i].sd;
            tick();
            check($sformatf("vec%0d_mode", i + 1), 32'(bus.mode_o), 32'(tbl[i].mode));
            check($sformatf("vec%0d_led", i + 1), 32'(bus.led_out), 32'(tbl[i].led));
        end

        // Link loss in RUN: immediate FAULT, LEDs follow the fader.
        set_idle();
        bus.link_ok = 1'b0;
        tick();
        check("fault_entry_mode", 32'(bus.mode_o), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("fault%0d_mode", i), 32'(bus.mode_o), 32'd0);
            check($sformatf("fault%0d_led", i), 32'(bus.led_out), 32'(exp_fault_led));
        end

        // Restore: 16 good edges back to CYLON; a flash started during FAULT carries over.
        bus.link_ok = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            bus.evt_i = (i == 15) ? 4'b1000 : 4'b0000;
            tick();
            check($sformatf("restore%0d_mode", i), 32'(bus.mode_o), (i < 16) ? 32'd0 : 32'd1);
            check($sformatf("restore%0d_led", i), 32'(bus.led_out), 32'(exp_fault_led));
        end
        bus.evt_i = 4'h0;
        for (int i = 17; i <= 21; i++) begin
            tick();
            check($sformatf("restore%0d_led", i), 32'(bus.led_out),
                  (i <= 20) ? 32'h81 : 32'h02);
        end

        // Asynchronous reset mid-flash: output clears without waiting for a clock edge.
        bus.evt_i = 4'b0100;
        tick();
        bus.evt_i = 4'h0;
        tick();
        check("pre_reset_flash", 32'(bus.led_out[6]), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_led", 32'(bus.led_out), 32'h00);
        check("async_reset_mode", 32'(bus.mode_o), 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("post_reset%0d_mode", i), 32'(bus.mode_o), 32'd0);
            check($sformatf("post_reset%0d_led", i), 32'(bus.led_out), 32'(exp_fault_led));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
